// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared types, field offsets and word assembly for the control-word decode pipe.
// Feature macro: CTRL_DECODE_PARITY_EN (adds registered out_par).
package ctrl_decode_pkg;

    typedef enum logic [1:0] {
        CLS_A     = 2'd0,
        CLS_B     = 2'd1,
        CLS_C     = 2'd2,
        CLS_MULTI = 2'd3
    } ctrl_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_EXPAND = 2'd2
    } ctrl_state_e;

    localparam int CLS_W       = 2;
    localparam int CLS_OH_W    = 4;
    localparam int CLS_LSB     = 0;
    localparam int FUNC_LSB    = CLS_LSB + CLS_OH_W;
    localparam int MAX_FUNC_OH = 32;
    localparam int MAX_CNT_W   = 8;
    localparam int MAX_CTRL_W  = 64;

    function automatic int opc_width(input int func_w, input int cnt_w);
        return CLS_W + func_w + cnt_w;
    endfunction

    function automatic int ctrl_width(input int func_w, input int cnt_w);
        return CLS_OH_W + (1 << func_w) + cnt_w + 2;
    endfunction

    // Field positions above the func one-hot move with func_w, so they are
    // computed here; callers truncate the result to their own word width.
    function automatic logic [MAX_CTRL_W-1:0] ctrl_word(
        input logic [CLS_OH_W-1:0]    cls,
        input logic [MAX_FUNC_OH-1:0] func,
        input logic [MAX_CNT_W-1:0]   idx,
        input logic                   first,
        input logic                   last,
        input int                     func_w,
        input int                     cnt_w
    );
        logic [MAX_CTRL_W-1:0] w;
        int                    idx_lsb;
        idx_lsb = FUNC_LSB + (1 << func_w);
        w = MAX_CTRL_W'(cls) << CLS_LSB;
        w = w | (MAX_CTRL_W'(func) << FUNC_LSB);
        w = w | (MAX_CTRL_W'(idx) << idx_lsb);
        w = w | (MAX_CTRL_W'(first) << (idx_lsb + cnt_w));
        w = w | (MAX_CTRL_W'(last) << (idx_lsb + cnt_w + 1));
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Fetch-side and datapath-side handshakes of the decode pipe bundled in one interface.
// out_par exists only when CTRL_DECODE_PARITY_EN is defined.
interface ctrl_decode_pipe_if #(
    parameter int FUNC_W = 3,
    parameter int CNT_W  = 2
);
    import ctrl_decode_pkg::*;

    localparam int OPC_W  = opc_width(FUNC_W, CNT_W);
    localparam int CTRL_W = ctrl_width(FUNC_W, CNT_W);

    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef CTRL_DECODE_PARITY_EN
    logic              out_par;

    modport master (
        output in_valid, in_opc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_par
    );

    modport slave (
        input  in_valid, in_opc, out_ready,
        output in_ready, out_valid, out_ctrl, out_par
    );
`else
    modport master (
        output in_valid, in_opc, out_ready,
        input  in_ready, out_valid, out_ctrl
    );

    modport slave (
        input  in_valid, in_opc, out_ready,
        output in_ready, out_valid, out_ctrl
    );
`endif

endinterface

// File: rtl/ctrl_onehot_enc.sv
// Binary to one-hot encoder; used for the class and function fields.
module ctrl_onehot_enc #(
    parameter int IN_W = 2
) (
    input  logic [IN_W-1:0]      bin,
    output logic [2**IN_W-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Handshaked opcode decoder that expands MULTI opcodes into counted micro-op words.
// Define CTRL_DECODE_PARITY_EN to add the registered even-parity output out_par.
//
// state  | meaning
// IDLE   | output register empty
// HOLD   | word presented, no micro-ops remain after it
// EXPAND | word presented, more micro-ops of this opcode remain
import ctrl_decode_pkg::*;

module ctrl_decode_pipe #(
    parameter int FUNC_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_decode_pipe_if.slave bus
);

    localparam int OPC_W     = opc_width(FUNC_W, CNT_W);
    localparam int FUNC_OH_W = 2**FUNC_W;
    localparam int CTRL_W    = ctrl_width(FUNC_W, CNT_W);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] HOLD   = ST_HOLD;
    localparam logic [1:0] EXPAND = ST_EXPAND;

    logic [1:0]           state_q, state_d;
    logic [CLS_W-1:0]     cls_q, cls_d;
    logic [FUNC_W-1:0]    func_q, func_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     idx_q, idx_d, idx_inc;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [CLS_OH_W-1:0]  cls_oh;
    logic [FUNC_OH_W-1:0] func_oh;
    logic [CLS_W-1:0]     in_cls;
    logic [FUNC_W-1:0]    in_func;
    logic [CNT_W-1:0]     in_cnt;
    logic                 in_ready, accept, consume;
    logic                 word_ld, go_idle, first_d, last_d;

    assign in_cls  = bus.in_opc[OPC_W-1 -: CLS_W];
    assign in_func = bus.in_opc[CNT_W +: FUNC_W];
    assign in_cnt  = bus.in_opc[CNT_W-1:0];

    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = (state_q != IDLE) && bus.out_ready;
    assign idx_inc  = idx_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        func_d  = func_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        first_d = 1'b1;
        last_d  = 1'b1;
        word_ld = 1'b0;
        go_idle = 1'b0;
        if (accept) begin
            // SINGLE classes ignore the count field, so store zero to make them one word.
            word_ld = 1'b1;
            cls_d   = in_cls;
            func_d  = in_func;
            cnt_d   = (in_cls == CLS_MULTI) ? in_cnt : '0;
            idx_d   = '0;
            last_d  = (cnt_d == '0);
            state_d = last_d ? HOLD : EXPAND;
        end else if (consume) begin
            if (state_q == EXPAND) begin
                word_ld = 1'b1;
                idx_d   = idx_inc;
                first_d = 1'b0;
                last_d  = (idx_inc == cnt_q);
                state_d = last_d ? HOLD : EXPAND;
            end else begin
                go_idle = 1'b1;
                state_d = IDLE;
            end
        end
    end

    ctrl_onehot_enc #(.IN_W(CLS_W)) u_cls_enc (
        .bin    (cls_d),
        .onehot (cls_oh)
    );

    ctrl_onehot_enc #(.IN_W(FUNC_W)) u_func_enc (
        .bin    (func_d),
        .onehot (func_oh)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        if (word_ld) begin
            ctrl_d = CTRL_W'(ctrl_word(cls_oh, MAX_FUNC_OH'(func_oh), MAX_CNT_W'(idx_d),
                                       first_d, last_d, FUNC_W, CNT_W));
        end else if (go_idle) begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= '0;
            func_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_ctrl  = ctrl_q;

`ifdef CTRL_DECODE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^ctrl_d;
        end
    end

    assign bus.out_par = par_q;
`endif

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Pipelined, parametrised control-word decoder that generalises the combinational opcode-to-control decoder into a sequenced, handshaked block. It accepts one opcode per transaction, registers the decoded one-hot control word, and expands multi-cycle opcodes into a counted sequence of micro-op control words. It sits between instruction fetch (upstream valid/ready) and datapath control (downstream valid/ready).

## Interface
- `FUNC_W`, default 3: function-field width; the function one-hot is `2**FUNC_W` bits wide.
- `CNT_W`, default 2: repeat-count field width; at most `2**CNT_W` micro-ops per opcode.
- Derived: `OPC_W = 2 + FUNC_W + CNT_W` (7); `CTRL_W = 4 + 2**FUNC_W + CNT_W + 2` (16).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: opcode valid.
- `in_ready` out 1: block accepts opcode this cycle.
- `in_opc` in `OPC_W`: `[OPC_W-1:OPC_W-2]` class, `[CNT_W+FUNC_W-1:CNT_W]` func, `[CNT_W-1:0]` cnt.
- `out_valid` out 1: control word valid.
- `out_ready` in 1: downstream consumes the word.
- `out_ctrl` out `CTRL_W`: decoded control word.
- `out_par` out 1: even parity of `out_ctrl` (present only with the macro below).

## Operation
- Control word layout: `[3:0]` class one-hot; `[4+2**FUNC_W-1:4]` func one-hot; next `CNT_W` bits uop index; next bit FIRST; MSB LAST.
- Classes 0–2 (SINGLE): one micro-op, index 0, FIRST=LAST=1; the cnt field is ignored.
- Class 3 (MULTI): `cnt+1` micro-ops, index 0..cnt; FIRST only on index 0, LAST only on index cnt. cnt=0 gives a single word with FIRST=LAST=1.
- FSM states:
  - IDLE: output register empty.
  - HOLD: word presented, no remaining micro-ops.
  - EXPAND: word presented, more micro-ops remain.
- Transitions:
  - IDLE -> HOLD/EXPAND on accept.
  - HOLD: on consume, go to IDLE, or to HOLD/EXPAND if a new opcode is accepted in the same cycle.
  - EXPAND: on consume, increment index; enter HOLD when the next word is LAST.
- `in_ready = (state==IDLE) | (state==HOLD & out_ready)`. `in_ready` never depends on `in_valid`.
- Latched opcode fields (class, func, cnt) are held in registers for the whole expansion; `in_opc` is sampled only on accept.
- Output stability: while `out_valid & ~out_ready`, `out_ctrl` and `out_valid` hold.

## Timing
- Reset values: `out_valid=0`, `out_ctrl=0`, `in_ready=1` (IDLE), index counter 0, `out_par=0`.
- Latency: accept at edge N puts the word on `out_ctrl` with `out_valid=1` after edge N; it is visible in cycle N+1.
- Throughput: one SINGLE opcode per cycle with `out_ready` held high, with no bubbles. A MULTI with cnt=k occupies k+1 output cycles, and `in_ready=0` during the first k of them.
- Simultaneous consume and accept in HOLD: the new word replaces the old one at the same edge, with no gap.
- Reset asserted mid-expansion: the sequence is abandoned, the block returns to IDLE next cycle, and no LAST word is emitted.
- Index counter: `CNT_W` bits. It never wraps, because the maximum index equals cnt ≤ `2**CNT_W-1`.

## Configuration
- `CTRL_DECODE_PARITY_EN` defined: `out_par` port exists and is registered alongside `out_ctrl` as `^out_ctrl`.
- `CTRL_DECODE_PARITY_EN` not defined: the port and logic are absent; all other behaviour is identical.

## Structure
- Package `ctrl_decode_pkg`:
  - class enum `CLS_A=0, CLS_B=1, CLS_C=2, CLS_MULTI=3`
  - field-offset localparams
  - FSM state enum
  - pure function `ctrl_word(cls, func, idx, first, last)`
- One sub-module `ctrl_onehot_enc`: parametrised binary-to-one-hot encoder, instantiated for class and func.

## Test plan
- Reset, then idle: `out_valid=0`, `out_ctrl=16'h0000`, `in_ready=1`.
- `in_opc=7'b0010110`, `out_ready=1`: next cycle `out_ctrl=16'hC201`, `out_valid=1`, then `out_valid=0`.
- `in_opc=7'b1100010`, `out_ready=1`: three consecutive words `16'h4018`, `16'h1018`, `16'hA018`; `in_ready=0` for the first two of those cycles.
- Back-to-back SINGLE opcodes `7'b0000000` and `7'b0100100`: words `16'hC011` and `16'hC022` in consecutive cycles, with no bubble.
- `out_ready=0` for 3 cycles after the first word of a MULTI: `out_ctrl` holds `16'h4018` and `in_ready=0`; sequence resumes on release.
- Reset asserted during the second micro-op: next cycle `out_valid=0`, IDLE, and the next opcode decodes from index 0. With `CTRL_DECODE_PARITY_EN`, `16'hC201` gives `out_par=0` and `16'h4018` gives `out_par=1`.
